// File: rtl/xoodyak_pkg.sv
// Shared types and widths for the Xoodyak job arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xoodyak_pkg;

  localparam int TEXT_W = 192;
  localparam int BLK_W  = 128;

  localparam logic OP_ENC = 1'b0;
  localparam logic OP_DEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/xoodyak_arb_if.sv
// Request, core and response bundle between requesters, arbiter and Xoodyak core.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready per requester, resp_valid/resp_ready on results.
interface xoodyak_arb_if;
  import xoodyak_pkg::*;

  // requester side, one lane per requester
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0]             req_opmode;
  logic [1:0][TEXT_W-1:0] req_text;
  logic [1:0][BLK_W-1:0]  req_key;
  logic [1:0][BLK_W-1:0]  req_nonce;
  logic [1:0][BLK_W-1:0]  req_ad;
  logic [1:0][BLK_W-1:0]  req_tag;

  // core side
  logic              core_start;
  logic [TEXT_W-1:0] core_textin;
  logic [BLK_W-1:0]  core_key;
  logic [BLK_W-1:0]  core_nonce;
  logic [BLK_W-1:0]  core_assodata;
  logic [BLK_W-1:0]  core_verif;
  logic              core_opmode;
  logic [TEXT_W-1:0] core_textout;
  logic [BLK_W-1:0]  core_authdata;
  logic              core_sqzdone;
  logic              core_verify;

  // response side
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [TEXT_W-1:0] resp_text;
  logic [BLK_W-1:0]  resp_tag;
  logic              resp_verify;
  logic              resp_err;

  logic              busy;

  // arbiter view
  modport slave (
    input  req_valid, req_opmode, req_text, req_key, req_nonce, req_ad, req_tag,
    output req_ready,
    output core_start, core_textin, core_key, core_nonce, core_assodata, core_verif, core_opmode,
    input  core_textout, core_authdata, core_sqzdone, core_verify,
    output resp_valid, resp_id, resp_text, resp_tag, resp_verify, resp_err,
    input  resp_ready,
    output busy
  );

  // requesters + core + consumer view
  modport master (
    output req_valid, req_opmode, req_text, req_key, req_nonce, req_ad, req_tag,
    input  req_ready,
    input  core_start, core_textin, core_key, core_nonce, core_assodata, core_verif, core_opmode,
    output core_textout, core_authdata, core_sqzdone, core_verify,
    input  resp_valid, resp_id, resp_text, resp_tag, resp_verify, resp_err,
    output resp_ready,
    input  busy
  );

endinterface

// File: rtl/xoodyak_rr_arb2.sv
// Two-way round-robin grant with a last-grant pointer.
// Latency: grant is combinational from req; pointer updates on the accepting edge.
// Backpressure: pointer only moves when advance is asserted by the parent.
module xoodyak_rr_arb2 (
  input  logic       eph1,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // last = id of the most recent grant; reset to 1 so requester 0 wins first contention
  logic last;

  // pick the requester not granted last when both ask
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // remember who won once the grant is actually taken
  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      last <= 1'b1;
    end else if (advance && (|gnt)) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/xoodyak_arb.sv
// Arbitrates two requesters onto one Xoodyak core and returns results with id/err.
// Latency: grant to resp_valid = 2 + core cycles (start to sqzdone), or TIMEOUT_CYCLES+1 on abort.
// Backpressure: one job in flight; no grant until the response is taken by resp_ready.
module xoodyak_arb
  import xoodyak_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int NREQ           = 2
) (
  input  logic         eph1,
  input  logic         reset_n,
  xoodyak_arb_if.slave bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [NREQ-1:0]  gnt;
  logic             grant, done, timeout;

  xoodyak_rr_arb2 u_rr (
    .eph1    (eph1),
    .reset_n (reset_n),
    .req     (bus.req_valid),
    .advance (grant),
    .gnt     (gnt)
  );

  assign grant   = (state == IDLE) && (|bus.req_valid);
  assign cnt_inc = cnt + CNT_W'(1);
  // abort when the counter is about to reach TIMEOUT_CYCLES-1; sqzdone still has priority
  assign done    = (state == WAIT) && bus.core_sqzdone;
  assign timeout = (state == WAIT) && (cnt_inc == CNT_LAST);

  // state register
  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next state and the decoded handshake outputs
  always_comb begin
    state_nxt      = state;
    bus.core_start = 1'b0;
    bus.resp_valid = 1'b0;
    bus.busy       = (state != IDLE);
    bus.req_ready  = 2'b00;
    case (state)
      IDLE: begin
        // gated by reset_n so nothing is accepted while reset is held
        if (reset_n) bus.req_ready = gnt;
        if (grant) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        bus.core_start = 1'b1;
        state_nxt      = WAIT;
      end
      WAIT: begin
        if (done || timeout) state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // wait counter: cleared on launch, saturates instead of wrapping
  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state == LAUNCH) begin
      cnt <= '0;
    end else if ((state == WAIT) && (cnt != CNT_LAST)) begin
      cnt <= cnt_inc;
    end
  end

  // operand and id capture at grant; held until the next grant
  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      bus.resp_id       <= 1'b0;
      bus.core_textin   <= '0;
      bus.core_key      <= '0;
      bus.core_nonce    <= '0;
      bus.core_assodata <= '0;
      bus.core_verif    <= '0;
      bus.core_opmode   <= 1'b0;
    end else if (grant) begin
      bus.resp_id       <= gnt[1];
      bus.core_textin   <= bus.req_text[gnt[1]];
      bus.core_key      <= bus.req_key[gnt[1]];
      bus.core_nonce    <= bus.req_nonce[gnt[1]];
      bus.core_assodata <= bus.req_ad[gnt[1]];
      bus.core_verif    <= bus.req_tag[gnt[1]];
      bus.core_opmode   <= bus.req_opmode[gnt[1]];
    end
  end

  // result capture: core data on sqzdone, zeroed payload with err on timeout
  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      bus.resp_text   <= '0;
      bus.resp_tag    <= '0;
      bus.resp_verify <= 1'b0;
      bus.resp_err    <= 1'b0;
    end else if (done) begin
      bus.resp_text   <= bus.core_textout;
      bus.resp_tag    <= bus.core_authdata;
      bus.resp_verify <= bus.core_verify;
      bus.resp_err    <= 1'b0;
    end else if (timeout) begin
      bus.resp_text   <= '0;
      bus.resp_tag    <= '0;
      bus.resp_verify <= 1'b0;
      bus.resp_err    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xoodyak_arb.sv
// Self-checking bench for xoodyak_arb with a toy invertible core model.
// Latency: checks grant-to-response cycle counts against the rules.
// Backpressure: exercises held resp_ready, contention and mid-job reset.
module tb_xoodyak_arb;
  import xoodyak_pkg::*;

  localparam int TO = 8;

  logic eph1 = 1'b0;
  logic reset_n = 1'b0;
  always #5 eph1 = ~eph1;

  xoodyak_arb_if bus();

  xoodyak_arb #(.TIMEOUT_CYCLES(TO), .NREQ(2)) dut (
    .eph1    (eph1),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [191:0] text;
    logic [127:0] tag;
    logic         verify;
  } res_t;

  typedef struct {
    logic [1:0] mask;
    logic [1:0] opm;
    int         dly;
    bit         mute;
    bit         early;
    int         hold;
    int         e_id;
    int         e_err;
    int         e_lat;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int core_dly = 0;
  bit core_mute = 1'b0;
  int last_g = 1;

  // toy keystream / tag: stands in for the real core, invertible so round trips work
  function automatic logic [191:0] ks_f(input logic [127:0] k, input logic [127:0] n, input logic [127:0] a);
    return {k[127:64] ^ a[63:0], k ^ {n[63:0], n[127:64]} ^ a};
  endfunction

  function automatic logic [127:0] tag_f(input logic [127:0] k, input logic [127:0] n, input logic [127:0] a,
                                         input logic [191:0] pt);
    return {k[63:0], k[127:64]} ^ n ^ a ^ pt[127:0] ^ {2{pt[191:128]}};
  endfunction

  function automatic res_t core_f(input logic opm, input logic [191:0] tin, input logic [127:0] k,
                                  input logic [127:0] n, input logic [127:0] a, input logic [127:0] v);
    res_t r;
    logic [191:0] pt;
    r.text   = tin ^ ks_f(k, n, a);
    pt       = opm ? r.text : tin;
    r.tag    = tag_f(k, n, a, pt);
    r.verify = opm ? (v == r.tag) : v[0];
    return r;
  endfunction

  // core stand-in: sqzdone arrives core_dly+2 cycles after the start pulse
  int ccnt;
  bit cbusy;
  always @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      cbusy <= 1'b0;
      ccnt <= 0;
      bus.core_sqzdone <= 1'b0;
      bus.core_textout <= '0;
      bus.core_authdata <= '0;
      bus.core_verify <= 1'b0;
    end else begin
      bus.core_sqzdone <= 1'b0;
      if (bus.core_start) begin
        cbusy <= 1'b1;
        ccnt <= core_dly;
      end else if (cbusy) begin
        if (ccnt == 0) begin
          cbusy <= 1'b0;
          bus.core_sqzdone <= !core_mute;
          {bus.core_textout, bus.core_authdata, bus.core_verify} <=
            core_f(bus.core_opmode, bus.core_textin, bus.core_key, bus.core_nonce, bus.core_assodata, bus.core_verif);
        end else begin
          ccnt <= ccnt - 1;
        end
      end
    end
  end

  always @(posedge eph1) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < 2; i++) begin
      bus.req_text[i]  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.req_key[i]   = {$urandom, $urandom, $urandom, $urandom};
      bus.req_nonce[i] = {$urandom, $urandom, $urandom, $urandom};
      bus.req_ad[i]    = {$urandom, $urandom, $urandom, $urandom};
      bus.req_tag[i]   = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // reference rules: round-robin id, and response timing from core delay vs timeout
  function automatic int model_id(input logic [1:0] mask);
    if (mask == 2'b11) return (last_g == 1) ? 0 : 1;
    return mask[1] ? 1 : 0;
  endfunction

  function automatic int model_lat(input int dly, input bit mute);
    int sq;
    sq = 2 + (dly + 2);
    if (!mute && sq <= TO + 1) return sq;
    return TO + 1;
  endfunction

  function automatic int model_err(input int dly, input bit mute);
    return (!mute && (2 + dly + 2) <= TO + 1) ? 0 : 1;
  endfunction

  // one full job: grant, wait with operand-stability checks, response, optional hold
  task automatic run_job(input logic [1:0] mask, input logic [1:0] opm, input int dly, input bit mute,
                         input bit early, input int hold, input int e_id, input int e_err, input int e_lat);
    logic [191:0] e_txt;
    logic [127:0] e_key, e_non, e_ad, e_tag;
    logic e_opm;
    res_t e_res;
    res_t got;
    int gcyc, nstart;
    bit seen;
    core_dly = dly;
    core_mute = mute;
    bus.req_opmode = opm;
    bus.req_valid = mask;
    if (early) bus.resp_ready = 1'b1;
    #1;
    chk("grant_onehot", bus.req_ready, (e_id == 1) ? 2'b10 : 2'b01);
    gcyc = cyc;
    last_g = e_id;
    e_txt = bus.req_text[e_id];
    e_key = bus.req_key[e_id];
    e_non = bus.req_nonce[e_id];
    e_ad  = bus.req_ad[e_id];
    e_tag = bus.req_tag[e_id];
    e_opm = opm[e_id];
    e_res = core_f(e_opm, e_txt, e_key, e_non, e_ad, e_tag);
    if (e_err != 0) e_res = '0;
    nstart = 0;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge eph1);
      if (t == 0) begin
        if (mask != 2'b11) bus.req_valid = 2'b00;
        scramble();
      end
      if (bus.core_start) nstart++;
      chk("busy", bus.busy, 1);
      chk("no_regrant", bus.req_ready, 0);
      chk("core_textin", bus.core_textin, e_txt);
      chk("core_key", bus.core_key, e_key);
      chk("core_nonce", bus.core_nonce, e_non);
      chk("core_ad", bus.core_assodata, e_ad);
      chk("core_verif", bus.core_verif, e_tag);
      chk("core_opmode", bus.core_opmode, e_opm);
      if (bus.resp_valid) seen = 1'b1;
    end
    if (!seen) begin
      chk("resp_seen", 0, 1);
      bus.req_valid = 2'b00;
      bus.resp_ready = 1'b0;
      return;
    end
    chk("start_pulses", nstart, 1);
    chk("latency", cyc - gcyc, e_lat);
    chk("resp_id", bus.resp_id, e_id);
    chk("resp_err", bus.resp_err, e_err);
    chk("resp_text", bus.resp_text, e_res.text);
    chk("resp_tag", bus.resp_tag, e_res.tag);
    chk("resp_verify", bus.resp_verify, e_res.verify);
    got = {bus.resp_text, bus.resp_tag, bus.resp_verify};
    for (int h = 0; h < hold; h++) begin
      @(negedge eph1);
      chk("hold_valid", bus.resp_valid, 1);
      chk("hold_text", bus.resp_text, got.text);
      chk("hold_tag", {bus.resp_tag, bus.resp_verify, bus.resp_err, bus.resp_id},
          {got.tag, got.verify, e_err[0], e_id[0]});
    end
    bus.resp_ready = 1'b1;
    @(negedge eph1);
    chk("resp_done", {bus.resp_valid, bus.busy}, 2'b00);
    bus.resp_ready = 1'b0;
    bus.req_valid = 2'b00;
  endtask

  localparam logic [127:0] K0 = 128'h38393a3b3c3d3e3f3031323334353637;
  localparam logic [127:0] N0 = 128'h494a4b4c4d4e4f504142434445464748;
  localparam logic [127:0] A0 = 128'h696a6b6c6d6e6f706162636465666768;
  localparam logic [191:0] P0 = 192'h4d4e4f505152535455565758414243444546474849_4a4b4c;

  vec_t tbl[10];

  initial begin
    logic [191:0] ct;
    logic [127:0] tg;
    logic [1:0] m, o;
    int d, hd, rv;
    bit mu, ea;

    // expected id / err / latency per row, derived by hand from the rules
    tbl[0] = '{2'b11, 2'b00, 0, 1'b0, 1'b0, 0, 0, 0, 4};
    tbl[1] = '{2'b11, 2'b11, 2, 1'b0, 1'b0, 1, 1, 0, 6};
    tbl[2] = '{2'b11, 2'b01, 3, 1'b0, 1'b0, 0, 0, 0, 7};
    tbl[3] = '{2'b11, 2'b10, 1, 1'b0, 1'b0, 2, 1, 0, 5};
    tbl[4] = '{2'b10, 2'b00, 0, 1'b0, 1'b0, 0, 1, 0, 4};
    tbl[5] = '{2'b01, 2'b00, 5, 1'b0, 1'b0, 0, 0, 0, 9};
    tbl[6] = '{2'b01, 2'b00, 6, 1'b0, 1'b0, 0, 0, 1, 9};
    tbl[7] = '{2'b10, 2'b00, 0, 1'b1, 1'b0, 0, 1, 1, 9};
    tbl[8] = '{2'b11, 2'b00, 2, 1'b0, 1'b1, 0, 0, 0, 6};
    tbl[9] = '{2'b01, 2'b00, 1, 1'b0, 1'b0, 10, 0, 0, 5};

    bus.req_valid = 2'b11;
    bus.req_opmode = 2'b00;
    bus.resp_ready = 1'b0;
    scramble();

    // reset state, with requests already pending
    repeat (2) @(negedge eph1);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_core_key", bus.core_key, 0);
    chk("rst_resp_text", bus.resp_text, 0);
    chk("rst_resp_misc", {bus.resp_id, bus.resp_err, bus.resp_verify, bus.core_opmode}, 0);
    bus.req_valid = 2'b00;
    reset_n = 1'b1;

    // known-answer encrypt on requester 0, first posedge after reset
    bus.req_key[0] = K0;
    bus.req_nonce[0] = N0;
    bus.req_ad[0] = A0;
    bus.req_text[0] = P0;
    run_job(2'b01, 2'b00, 1, 1'b0, 1'b0, 0, 0, 0, 5);
    ct = bus.resp_text;
    tg = bus.resp_tag;

    // round trip on requester 1, then with one tag bit flipped
    for (int f = 0; f < 2; f++) begin
      bus.req_key[1] = K0;
      bus.req_nonce[1] = N0;
      bus.req_ad[1] = A0;
      bus.req_text[1] = ct;
      bus.req_tag[1] = (f == 0) ? tg : (tg ^ (128'd1 << 37));
      run_job(2'b10, 2'b10, 2, 1'b0, 1'b0, 0, 1, 0, 6);
      chk("rt_plain", bus.resp_text, P0);
      chk("rt_verify", bus.resp_verify, (f == 0) ? 1 : 0);
    end

    // directed table: contention, single-valid, timeout corners, backpressure
    for (int i = 0; i < 10; i++) begin
      run_job(tbl[i].mask, tbl[i].opm, tbl[i].dly, tbl[i].mute, tbl[i].early, tbl[i].hold,
              tbl[i].e_id, tbl[i].e_err, tbl[i].e_lat);
    end

    // reset pulsed during WAIT abandons the job
    core_dly = 0;
    core_mute = 1'b1;
    bus.req_valid = 2'b01;
    @(negedge eph1);
    bus.req_valid = 2'b00;
    repeat (2) @(negedge eph1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_outs", {bus.resp_valid, bus.core_start, bus.req_ready, bus.resp_err}, 0);
    chk("mid_rst_core", bus.core_textin, 0);
    last_g = 1;
    @(negedge eph1);
    reset_n = 1'b1;
    rv = 0;
    for (int t = 0; t < 15; t++) begin
      @(negedge eph1);
      if (bus.resp_valid) rv++;
    end
    chk("mid_rst_no_resp", rv, 0);

    // pointer is back at 1: requester 0 wins contention
    run_job(2'b11, 2'b00, 0, 1'b0, 1'b0, 0, model_id(2'b11), model_err(0, 1'b0), model_lat(0, 1'b0));

    // randomized jobs against the reference rules
    for (int j = 0; j < 40; j++) begin
      m  = 2'($urandom_range(1, 3));
      o  = 2'($urandom_range(0, 3));
      d  = $urandom_range(0, 7);
      mu = ($urandom_range(0, 7) == 0);
      ea = ($urandom_range(0, 5) == 0);
      hd = ea ? 0 : $urandom_range(0, 3);
      run_job(m, o, d, mu, ea, hd, model_id(m), model_err(d, mu), model_lat(d, mu));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/xoodyak_arb.md
XOODYAK_ARB -- requirements
Module: xoodyak_arb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles spent in WAIT before the job aborts.
REQ-002 Parameter NREQ, default 2, fixed at 2: number of requesters.
REQ-003 eph1  in  1  sole clock; all state updates on posedge eph1.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  2  per-requester job request.
REQ-006 req_ready  out  2  one-hot accept; asserted only in IDLE, for the granted requester.
REQ-007 req_opmode  in  2  per requester: 0 = encrypt, 1 = decrypt.
REQ-008 req_text / req_key / req_nonce / req_ad / req_tag  in  2x192 / 2x128 / 2x128 / 2x128 / 2x128  per-requester operands.
REQ-009 core_start  out  1  single-cycle start pulse to xoodyak_build.
REQ-010 core_textin / core_key / core_nonce / core_assodata / core_verif / core_opmode  out  192 / 128 / 128 / 128 / 128 / 1  registered operands to the core.
REQ-011 core_textout / core_authdata / core_sqzdone / core_verify  in  192 / 128 / 1 / 1  core results.
REQ-012 resp_valid / resp_id / resp_text / resp_tag / resp_verify / resp_err  out  1 / 1 / 192 / 128 / 1 / 1  result channel.
REQ-013 resp_ready  in  1  consumer accepts the response.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, LAUNCH, WAIT, RESP; reset state is IDLE.
REQ-016 IDLE: if any req_valid is set, grant one requester, assert its req_ready combinationally, latch its operands and id into the operand registers, then go to LAUNCH.
REQ-017 Round-robin arbitration: when both requesters are valid, grant the one not granted last; a single valid requester always wins.
REQ-018 last-grant pointer resets to 1, so requester 0 wins the first contended arbitration.
REQ-019 LAUNCH lasts exactly 1 cycle: core_start = 1, counter cleared, next state WAIT.
REQ-020 core_* operand outputs are driven from registers and stay stable from LAUNCH through the end of RESP.
REQ-021 WAIT: counter increments each cycle.
REQ-022 When core_sqzdone = 1 in WAIT: capture core_textout, core_authdata and core_verify into the resp registers, set resp_err = 0, go to RESP.
REQ-023 Timeout: if the counter reaches TIMEOUT_CYCLES-1 with no sqzdone, go to RESP with resp_err = 1 and resp_text, resp_tag and resp_verify all 0.
REQ-024 sqzdone in the same cycle as timeout: sqzdone wins and resp_err = 0.
REQ-025 RESP: resp_valid = 1 with all resp_* held stable until resp_ready = 1, then go to IDLE.
REQ-026 resp_ready = 1 while resp_valid = 0 has no effect.
REQ-027 A new grant is issued no earlier than the cycle after RESP completes; there is no back-to-back overlap.
REQ-028 core_sqzdone outside WAIT is ignored.
REQ-029 resp_verify is meaningful only for decrypt jobs; for encrypt jobs it passes through the core value unchanged.
REQ-030 Job latency: grant to resp_valid = 2 + (cycles from core_start to core_sqzdone).
REQ-031 The counter width is clog2(TIMEOUT_CYCLES) and the counter never wraps.

Reset
REQ-032 reset_n low asynchronously forces: state IDLE, counter 0, last-grant pointer 1, and every output 0 (req_ready, core_start, core_*, resp_*, busy).
REQ-033 Reset mid-job abandons the job; no response is produced, and the core is reset by the same reset_n.
REQ-034 After reset_n deasserts, the first grant occurs on the first posedge eph1 with req_valid set.

Structure
REQ-035 A shared package xoodyak_pkg holds the FSM state enum (arb_state_t), operand width constants (TEXT_W = 192, BLK_W = 128) and OP_ENC / OP_DEC.
REQ-036 One sub-module, xoodyak_rr_arb2, implements the 2-way round-robin grant and its pointer.
REQ-037 xoodyak_arb does not instantiate the core; xoodyak_build is connected beside it at the parent level.

Verification
REQ-038 Encrypt, requester 0 only: key 0x38393a3b3c3d3e3f3031323334353637, nonce 0x494a4b4c4d4e4f504142434445464748, ad 0x696a6b6c6d6e6f706162636465666768, text 0x4d4e...4a4b4c -> single core_start pulse, resp_id = 0, resp_err = 0, resp_text/resp_tag equal to the reference model.
REQ-039 Round trip: requester 1 decrypts the ciphertext and tag from REQ-038 -> resp_text equals the original plaintext, resp_verify = 1; a single flipped tag bit -> resp_verify = 0.
REQ-040 Contention: both req_valid held high for 4 jobs -> grant order 0, 1, 0, 1, and operands never change during WAIT.
REQ-041 Timeout: TIMEOUT_CYCLES = 8, core_sqzdone held 0 -> resp_err = 1 exactly 9 cycles after grant, with zero data.
REQ-042 Backpressure and reset: resp_ready held low for 10 cycles -> resp_* stable; reset_n pulsed low during WAIT -> busy = 0 immediately and no response is produced.
